// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA controller: register offsets, CTRL bit positions
// and FSM state encoding.
package dma_ctrl_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_DONE    = 2;
    localparam int CTRL_SRC_FIX = 3;
    localparam int CTRL_DST_FIX = 4;
    localparam int CTRL_FILL    = 5;
    localparam int CTRL_ABORT   = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_RD      = 3'd2,
        ST_CAP     = 3'd3,
        ST_WR      = 3'd4,
        ST_RESTORE = 3'd5,
        ST_GAP     = 3'd6
    } dma_state_t;

endpackage

// File: rtl/dma_ctrl_regfile.sv
// DMA slave register block: address decode, SRC/DST/LEN/CTRL storage and read mux.
// FILL storage exists only when DMA_FILL_EN is defined; otherwise CTRL bit 5 reads 0.
module dma_ctrl_regfile
    import dma_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0440
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        grant,
    input  logic        word_step,
    input  logic        finish,
    output logic [15:0] reg_rdata,
    output logic [15:0] src,
    output logic [15:0] dst,
    output logic [15:0] len,
    output logic        ie,
    output logic        done,
    output logic        abort,
    output logic        fill,
    output logic        start_go
);

    logic [15:0] offset;
    logic [1:0]  sel;
    logic        hit;
    logic        wr_en;
    logic        wr_src;
    logic        wr_dst;
    logic        wr_len;
    logic        wr_ctrl;
    logic        start_empty;
    logic        busy;
    logic        src_fix;
    logic        dst_fix;

    assign offset = bus_addr - BASE_ADDR;
    assign hit    = (offset[15:2] == 14'd0);
    assign sel    = offset[1:0];

    // The DMA's own master cycles are never stored, even if they address this block.
    assign wr_en   = bus_we && !grant && hit;
    assign wr_src  = wr_en && (sel == REG_SRC);
    assign wr_dst  = wr_en && (sel == REG_DST);
    assign wr_len  = wr_en && (sel == REG_LEN);
    assign wr_ctrl = wr_en && (sel == REG_CTRL);

    assign start_go    = wr_ctrl && !busy && bus_wdata[CTRL_START] && (len != 16'd0);
    assign start_empty = wr_ctrl && !busy && bus_wdata[CTRL_START] && (len == 16'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            busy    <= 1'b0;
            ie      <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
            src_fix <= 1'b0;
            dst_fix <= 1'b0;
        end else begin
            if (wr_src && !busy)
                src <= bus_wdata;
            else if (word_step && !src_fix && !fill)
                src <= src + 16'd1;

            if (wr_dst && !busy)
                dst <= bus_wdata;
            else if (word_step && !dst_fix)
                dst <= dst + 16'd1;

            if (wr_len && !busy)
                len <= bus_wdata;
            else if (word_step)
                len <= len - 16'd1;

            if (start_go)
                busy <= 1'b1;
            else if (finish)
                busy <= 1'b0;

            // A set in the same cycle as a write-1-clear wins.
            if (finish || start_empty)
                done <= 1'b1;
            else if (wr_ctrl && bus_wdata[CTRL_DONE])
                done <= 1'b0;

            if (finish)
                abort <= 1'b0;
            else if (wr_ctrl && busy && bus_wdata[CTRL_ABORT])
                abort <= 1'b1;

            if (wr_ctrl)
                ie <= bus_wdata[CTRL_IE];

            if (wr_ctrl && !busy) begin
                src_fix <= bus_wdata[CTRL_SRC_FIX];
                dst_fix <= bus_wdata[CTRL_DST_FIX];
            end
        end
    end

`ifdef DMA_FILL_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            fill <= 1'b0;
        else if (wr_ctrl && !busy)
            fill <= bus_wdata[CTRL_FILL];
    end
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        reg_rdata = '0;
        if (hit) begin
            case (sel)
                REG_SRC: reg_rdata = src;
                REG_DST: reg_rdata = dst;
                REG_LEN: reg_rdata = len;
                REG_CTRL: begin
                    reg_rdata[CTRL_START]   = busy;
                    reg_rdata[CTRL_IE]      = ie;
                    reg_rdata[CTRL_DONE]    = done;
                    reg_rdata[CTRL_SRC_FIX] = src_fix;
                    reg_rdata[CTRL_DST_FIX] = dst_fix;
                    reg_rdata[CTRL_FILL]    = fill;
                    reg_rdata[CTRL_ABORT]   = abort;
                end
                default: reg_rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/dma_ctrl.sv
// Memory-to-memory DMA engine: bus-ownership FSM, data register, burst counter and
// master outputs. Optional constant-fill mode is built only with DMA_FILL_EN defined.
//
//   state   | meaning
//   IDLE    | CPU runs; wait for START with LEN != 0
//   ARB     | CPU stalled, bus not yet granted (handover cycle)
//   RD      | DMA drives SRC as read address
//   CAP     | SRC held; read data captured at the edge
//   WR      | DMA writes data (or fill constant) to DST; counters step
//   RESTORE | bus back to CPU, CPU still stalled so its read is re-presented
//   GAP     | one guaranteed CPU cycle between bursts
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0440,
    parameter int          BURST_LEN = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_bus_we,
    input  logic [15:0] i_bus_addr,
    input  logic [15:0] i_bus_wdata,
    output logic [15:0] o_reg_rdata,
    input  logic [15:0] i_bus_rdata,
    output logic [15:0] o_m_addr,
    output logic [15:0] o_m_wdata,
    output logic        o_m_we,
    output logic        o_grant,
    output logic        o_cpu_ce,
    output logic        o_int
);

    localparam int            BW         = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_INIT = BW'(BURST_LEN);

    dma_state_t    state;
    dma_state_t    state_nxt;
    logic [15:0]   data_q;
    logic [BW-1:0] burst_left;
    logic [15:0]   src;
    logic [15:0]   dst;
    logic [15:0]   len;
    logic          ie;
    logic          done;
    logic          abort;
    logic          fill;
    logic          start_go;
    logic          word_step;
    logic          finish;
    logic          m_we;

    dma_ctrl_regfile #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regfile (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .bus_we    (i_bus_we),
        .bus_addr  (i_bus_addr),
        .bus_wdata (i_bus_wdata),
        .grant     (o_grant),
        .word_step (word_step),
        .finish    (finish),
        .reg_rdata (o_reg_rdata),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .ie        (ie),
        .done      (done),
        .abort     (abort),
        .fill      (fill),
        .start_go  (start_go)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            data_q     <= '0;
            burst_left <= BURST_INIT;
        end else begin
            state <= state_nxt;
            if (state == ST_CAP)
                data_q <= i_bus_rdata;
            if (state == ST_WR)
                burst_left <= burst_left - BW'(1);
            else if (state == ST_IDLE || state == ST_GAP)
                burst_left <= BURST_INIT;
        end
    end

    always_comb begin
        state_nxt = state;
        word_step = 1'b0;
        finish    = 1'b0;
        o_grant   = 1'b0;
        o_cpu_ce  = 1'b0;
        o_m_addr  = '0;
        o_m_wdata = '0;
        m_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                o_cpu_ce = 1'b1;
                if (start_go)
                    state_nxt = ST_ARB;
            end
            ST_ARB: begin
                state_nxt = fill ? ST_WR : ST_RD;
            end
            ST_RD: begin
                o_grant   = 1'b1;
                o_m_addr  = src;
                state_nxt = ST_CAP;
            end
            ST_CAP: begin
                o_grant   = 1'b1;
                o_m_addr  = src;
                state_nxt = ST_WR;
            end
            ST_WR: begin
                o_grant   = 1'b1;
                o_m_addr  = dst;
                o_m_wdata = fill ? src : data_q;
                m_we      = 1'b1;
                word_step = 1'b1;
                // len and burst_left are judged as they will be after this word.
                if (len != 16'd1 && burst_left != BW'(1) && !abort)
                    state_nxt = fill ? ST_WR : ST_RD;
                else
                    state_nxt = ST_RESTORE;
            end
            ST_RESTORE: begin
                if (len != 16'd0 && !abort) begin
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            ST_GAP: begin
                o_cpu_ce  = 1'b1;
                state_nxt = ST_ARB;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_m_we = m_we && i_reset_n;
    assign o_int  = done && ie;

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: bus/memory model, CPU program counter model and a
// write scoreboard. The fill scenario is compiled in when DMA_FILL_EN is defined.
module tb_dma_ctrl;

    localparam logic [15:0] BASE = 16'h0440;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] rdata_q;
    logic [15:0] o_reg_rdata;
    logic [15:0] o_m_addr;
    logic [15:0] o_m_wdata;
    logic        o_m_we;
    logic        o_grant;
    logic        o_cpu_ce;
    logic        o_int;

    int          n_cmp;
    int          n_bad;
    int          pc;
    wr_t         sb[$];
    wr_t         exp_w;
    logic [15:0] mem [logic [15:0]];

    dma_ctrl #(
        .BASE_ADDR (16'h0440),
        .BURST_LEN (4)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_bus_we    (bus_we),
        .i_bus_addr  (bus_addr),
        .i_bus_wdata (bus_wdata),
        .o_reg_rdata (o_reg_rdata),
        .i_bus_rdata (rdata_q),
        .o_m_addr    (o_m_addr),
        .o_m_wdata   (o_m_wdata),
        .o_m_we      (o_m_we),
        .o_grant     (o_grant),
        .o_cpu_ce    (o_cpu_ce),
        .o_int       (o_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SoC bus mux: the DMA master owns the bus while granted
    assign bus_we    = o_grant ? o_m_we    : cpu_we;
    assign bus_addr  = o_grant ? o_m_addr  : cpu_addr;
    assign bus_wdata = o_grant ? o_m_wdata : cpu_wdata;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        rdata_q <= mem_rd(bus_addr);
        if (bus_we)
            mem[bus_addr] = bus_wdata;
    end

    always @(posedge clk) begin
        if (!reset_n)
            pc <= 0;
        else if (o_cpu_ce)
            pc <= pc + 1;
    end

    always @(negedge clk) begin
        if (reset_n && o_grant && o_m_we) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_write addr=%h data=%h", o_m_addr, o_m_wdata);
            end else begin
                exp_w = sb.pop_front();
                if (o_m_addr !== exp_w.addr || o_m_wdata !== exp_w.data) begin
                    n_bad++;
                    $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                             o_m_addr, o_m_wdata, exp_w.addr, exp_w.data);
                end
            end
        end
    end

    task automatic reg_write(input logic [1:0] off, input logic [15:0] d);
        cpu_addr  = BASE + {14'd0, off};
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(negedge clk);
        cpu_we    = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] off, output logic [15:0] d);
        cpu_addr = BASE + {14'd0, off};
        #1;
        d = o_reg_rdata;
    endtask

    task automatic wait_done(input string name);
        logic [15:0] v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!o_grant) begin
                reg_read(2'd3, v);
                if (!v[0]) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout busy still 1 after 200 cycles, expected 0", name);
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        n_cmp++;
        if (o_grant !== 1'b0 || o_cpu_ce !== 1'b1 || o_m_we !== 1'b0 || o_int !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got grant=%b ce=%b we=%b int=%b expected 0 1 0 0",
                     o_grant, o_cpu_ce, o_m_we, o_int);
        end
        n_cmp++;
        if (o_m_addr !== 16'h0 || o_m_wdata !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mbus got addr=%h wdata=%h expected 0 0", o_m_addr, o_m_wdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            reg_read(2'(r), v);
            n_cmp++;
            if (v !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_reg%0d got %h expected 0000", r, v);
            end
        end
        cpu_addr = 16'h0444;
        #1;
        n_cmp++;
        if (o_reg_rdata !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_outside_range got %h expected 0000", o_reg_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [15:0] v;
        int low;
        reg_write(2'd0, 16'h2000);
        reg_write(2'd1, 16'h0100);
        reg_write(2'd2, 16'd3);
        for (int i = 0; i < 3; i++)
            sb.push_back('{addr: 16'h0100 + 16'(i), data: pat(16'h2000 + 16'(i))});
        reg_write(2'd3, 16'h0001);
        low = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_cpu_ce) break;
            low++;
            @(negedge clk);
        end
        n_cmp++;
        if (low != 11) begin
            n_bad++;
            $display("FAIL single_stall got %0d cycles expected 11", low);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem_rd(16'h0100 + 16'(i)) !== pat(16'h2000 + 16'(i))) begin
                n_bad++;
                $display("FAIL single_ram%0d got %h expected %h", i,
                         mem_rd(16'h0100 + 16'(i)), pat(16'h2000 + 16'(i)));
            end
        end
        reg_read(2'd0, v);
        n_cmp++;
        if (v !== 16'h2003) begin n_bad++; $display("FAIL single_src got %h expected 2003", v); end
        reg_read(2'd2, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_bad++; $display("FAIL single_len got %h expected 0000", v); end
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0004) begin n_bad++; $display("FAIL single_ctrl got %h expected 0004", v); end
        n_cmp++;
        if (o_int !== 1'b0) begin n_bad++; $display("FAIL single_int_ie0 got %b expected 0", o_int); end
        @(negedge clk);
        reg_write(2'd3, 16'h0002);
        n_cmp++;
        if (o_int !== 1'b1) begin n_bad++; $display("FAIL single_int_ie1 got %b expected 1", o_int); end
        reg_write(2'd3, 16'h0004);
        n_cmp++;
        if (o_int !== 1'b0) begin n_bad++; $display("FAIL single_int_clr got %b expected 0", o_int); end
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_bad++; $display("FAIL single_ctrl_clr got %h expected 0000", v); end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL single_sb_left got %0d expected 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_bursts();
        logic [15:0] v;
        int grants, gap, pc_gap, pc_delta;
        int words[2];
        bit prev_g, gap_prev, sent;
        reg_write(2'd0, 16'h3000);
        reg_write(2'd1, 16'h0400);
        reg_write(2'd2, 16'd6);
        for (int i = 0; i < 6; i++)
            sb.push_back('{addr: 16'h0400 + 16'(i), data: pat(16'h3000 + 16'(i))});
        reg_write(2'd3, 16'h0001);
        grants = 0; gap = 0; pc_gap = 0; pc_delta = -1;
        words[0] = 0; words[1] = 0;
        prev_g = 1'b0; gap_prev = 1'b0; sent = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cpu_we = 1'b0;
            if (gap_prev) pc_delta = pc - pc_gap;
            gap_prev = 1'b0;
            if (o_grant && !prev_g) grants++;
            if (o_m_we && grants >= 1 && grants <= 2) words[grants-1]++;
            if (grants == 1 && !o_grant && o_cpu_ce) begin
                gap++;
                pc_gap   = pc;
                gap_prev = 1'b1;
                if (!sent) begin
                    // CPU uses its slot to try a LEN write while the engine is busy
                    cpu_addr  = BASE + 16'd2;
                    cpu_wdata = 16'd9;
                    cpu_we    = 1'b1;
                    sent      = 1'b1;
                end
            end
            prev_g = o_grant;
            @(negedge clk);
        end
        cpu_we = 1'b0;
        n_cmp++;
        if (grants != 2) begin n_bad++; $display("FAIL burst_grants got %0d expected 2", grants); end
        n_cmp++;
        if (words[0] != 4 || words[1] != 2) begin
            n_bad++;
            $display("FAIL burst_words got %0d,%0d expected 4,2", words[0], words[1]);
        end
        n_cmp++;
        if (gap != 1) begin n_bad++; $display("FAIL burst_gap got %0d expected 1", gap); end
        n_cmp++;
        if (pc_delta != 1) begin n_bad++; $display("FAIL burst_pc_step got %0d expected 1", pc_delta); end
        reg_read(2'd2, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_bad++; $display("FAIL busy_len_write got %h expected 0000", v); end
        reg_read(2'd1, v);
        n_cmp++;
        if (v !== 16'h0406) begin n_bad++; $display("FAIL burst_dst got %h expected 0406", v); end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL burst_sb_left got %0d expected 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        logic [15:0] v;
        int seen;
        reg_write(2'd3, 16'h0004);
        reg_write(2'd2, 16'd0);
        reg_write(2'd3, 16'h0001);
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0004) begin n_bad++; $display("FAIL zero_ctrl got %h expected 0004", v); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_grant || !o_cpu_ce) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL zero_no_grant got %0d busy cycles expected 0", seen); end
    endtask

    task automatic test_abort();
        logic [15:0] v;
        reg_write(2'd3, 16'h0004);
        reg_write(2'd0, 16'h2000);
        reg_write(2'd1, 16'h0500);
        reg_write(2'd2, 16'd5);
        sb.push_back('{addr: 16'h0500, data: pat(16'h2000)});
        reg_write(2'd3, 16'h0001);
        reg_write(2'd3, 16'h0080);
        wait_done("abort");
        reg_read(2'd2, v);
        n_cmp++;
        if (v !== 16'h0004) begin n_bad++; $display("FAIL abort_len got %h expected 0004", v); end
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0004) begin n_bad++; $display("FAIL abort_ctrl got %h expected 0004", v); end
        n_cmp++;
        if (mem_rd(16'h0501) !== pat(16'h0501)) begin
            n_bad++;
            $display("FAIL abort_no_more got %h expected %h", mem_rd(16'h0501), pat(16'h0501));
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL abort_sb_left got %0d expected 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [15:0] v;
        reg_write(2'd3, 16'h0004);
        reg_write(2'd0, 16'h2010);
        reg_write(2'd1, 16'hFFFF);
        reg_write(2'd2, 16'd2);
        sb.push_back('{addr: 16'hFFFF, data: pat(16'h2010)});
        sb.push_back('{addr: 16'h0000, data: pat(16'h2011)});
        reg_write(2'd3, 16'h0001);
        wait_done("wrap");
        reg_read(2'd1, v);
        n_cmp++;
        if (v !== 16'h0001) begin n_bad++; $display("FAIL wrap_dst got %h expected 0001", v); end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL wrap_sb_left got %0d expected 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        bit seen;
        reg_write(2'd3, 16'h0004);
        reg_write(2'd0, 16'h2020);
        reg_write(2'd1, 16'h0600);
        reg_write(2'd2, 16'd2);
        reg_write(2'd3, 16'h0001);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o_grant) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rstmid_grant got 0 expected 1 within 10 cycles"); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_cpu_ce !== 1'b1 || o_grant !== 1'b0 || o_m_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got ce=%b grant=%b we=%b expected 1 0 0",
                     o_cpu_ce, o_grant, o_m_we);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_rd(16'h0600) !== pat(16'h0600)) begin
            n_bad++;
            $display("FAIL rstmid_no_write got %h expected %h", mem_rd(16'h0600), pat(16'h0600));
        end
        reg_read(2'd2, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_bad++; $display("FAIL rstmid_len got %h expected 0000", v); end
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_bad++; $display("FAIL rstmid_ctrl got %h expected 0000", v); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [15:0] v;
`ifdef DMA_FILL_EN
        int low;
        reg_write(2'd3, 16'h0004);
        reg_write(2'd0, 16'hA5A5);
        reg_write(2'd1, 16'h0200);
        reg_write(2'd2, 16'd4);
        for (int i = 0; i < 4; i++)
            sb.push_back('{addr: 16'h0200 + 16'(i), data: 16'hA5A5});
        reg_write(2'd3, 16'h0021);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_cpu_ce) break;
            low++;
            @(negedge clk);
        end
        n_cmp++;
        if (low != 6) begin n_bad++; $display("FAIL fill_stall got %0d cycles expected 6", low); end
        reg_read(2'd0, v);
        n_cmp++;
        if (v !== 16'hA5A5) begin n_bad++; $display("FAIL fill_src got %h expected a5a5", v); end
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0024) begin n_bad++; $display("FAIL fill_ctrl got %h expected 0024", v); end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL fill_sb_left got %0d expected 0", sb.size()); end
        @(negedge clk);
`else
        reg_write(2'd3, 16'h0024);
        reg_read(2'd3, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_bad++; $display("FAIL fill_bit_ro got %h expected 0000", v); end
        @(negedge clk);
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        n_cmp     = 0;
        n_bad     = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_bursts();
        test_zero_len();
        test_abort();
        test_wrap();
        test_reset_mid();
        test_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
